tlc_input_conditioner: RTL

- Front-end stage directly upstream of the traffic light controller.
- Synchronises and debounces the raw MAINT switch and a pedestrian push-button.
- Latches pedestrian requests until the controller acknowledges them.
- Generates the single-cycle step enable that paces the controller from the 100 MHz board clock. This replaces the toggling divided clock with a clock-enable in the same clk domain.

---
 rtl/tlc_pkg.sv | 35 +++
 rtl/tlc_debounce.sv | 122 ++++++++++++
 rtl/tlc_input_conditioner.sv | 116 +++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared types, default rates and derived-constant helpers for
//               the traffic light controller input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    // Debounce FSM states; the debounced level is 1 in S_HI and S_WAIT_LO.
    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } db_state_t;

    localparam int unsigned C_DEF_CLK_HZ      = 100_000_000;
    localparam int unsigned C_DEF_TICK_HZ     = 2;
    localparam int unsigned C_DEF_DEBOUNCE_MS = 10;

    // Clock cycles between controller steps.
    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Consecutive stable samples required before a level change is accepted.
    function automatic int unsigned db_cycles(input int unsigned clk_hz,
                                              input int unsigned debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tlc_debounce
// Description : Two-flop synchroniser followed by a four-state debounce FSM.
//               'level' is the debounced level the FSM is about to enter, so
//               a consumer that registers it sees the change on the same edge
//               as the FSM state register.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_debounce
    import tlc_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned         C_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0]  C_CNT_LAST = C_CNT_W'(DB_CYCLES - 1);
    localparam bit                  C_SINGLE   = (DB_CYCLES == 1);

    logic               r_meta;
    logic               r_sync;
    db_state_t          r_state;
    db_state_t          w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;

    // Two-stage synchroniser; only the second stage feeds the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: a level must be seen DB_CYCLES times in a row to be
    // accepted; any opposite sample during the wait returns to the old level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_LO: begin
                if (r_sync) begin
                    if (C_SINGLE) begin
                        w_state_nxt = S_HI;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_WAIT_HI;
                        w_cnt_nxt   = C_CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            S_WAIT_HI: begin
                if (!r_sync) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_HI: begin
                if (!r_sync) begin
                    if (C_SINGLE) begin
                        w_state_nxt = S_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_WAIT_LO;
                        w_cnt_nxt   = C_CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            S_WAIT_LO: begin
                if (r_sync) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state.
    always_comb begin
        level = (w_state_nxt == S_HI) || (w_state_nxt == S_WAIT_LO);
    end

endmodule
`default_nettype wire

// File: rtl/tlc_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tlc_input_conditioner
// Description : Front end of the traffic light controller. Debounces the
//               MAINT switch and pedestrian button, latches pedestrian
//               requests until acknowledged, and produces the one-cycle step
//               enable 'tick' every TICK_DIV clocks.
//               Build option: define TLC_TICK_ALIGN_EN to restart the tick
//               period when maintenance mode ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_input_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned CLK_HZ      = C_DEF_CLK_HZ,
    parameter int unsigned TICK_HZ     = C_DEF_TICK_HZ,
    parameter int unsigned DEBOUNCE_MS = C_DEF_DEBOUNCE_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic maint_raw,
    input  logic ped_raw,
    input  logic ped_ack,
    output logic tick,
    output logic maint,
    output logic maint_rise,
    output logic maint_fall,
    output logic ped_req
);

    localparam int unsigned          TICK_DIV    = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned          DB_CYCLES   = db_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned          C_TCNT_W    = $clog2(TICK_DIV);
    localparam logic [C_TCNT_W-1:0]  C_TCNT_ONE  = C_TCNT_W'(1);
    localparam logic [C_TCNT_W-1:0]  C_TCNT_LAST = C_TCNT_W'(TICK_DIV - 1);

    logic                w_maint_lvl;
    logic                w_ped_lvl;
    logic                w_maint_fall_nxt;
    logic                w_ped_set;
    logic                w_tick_clear;
    logic                r_ped_lvl;
    logic [C_TCNT_W-1:0] r_tcnt;

    tlc_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_maint (
        .clk   (clk),
        .rst   (rst),
        .raw   (maint_raw),
        .level (w_maint_lvl)
    );

    tlc_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_ped (
        .clk   (clk),
        .rst   (rst),
        .raw   (ped_raw),
        .level (w_ped_lvl)
    );

    // Edge detection on the debounced levels, one cycle ahead of the registers.
    always_comb begin
        w_maint_fall_nxt = maint & ~w_maint_lvl;
        w_ped_set        = w_ped_lvl & ~r_ped_lvl;
`ifdef TLC_TICK_ALIGN_EN
        w_tick_clear     = w_maint_fall_nxt;
`else
        w_tick_clear     = 1'b0;
`endif
    end

    // Registered maintenance level and its one-cycle change pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maint      <= 1'b0;
            maint_rise <= 1'b0;
            maint_fall <= 1'b0;
        end else begin
            maint      <= w_maint_lvl;
            maint_rise <= w_maint_lvl & ~maint;
            maint_fall <= w_maint_fall_nxt;
        end
    end

    // Pedestrian request latch; a new press wins over a same-cycle ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_lvl <= 1'b0;
            ped_req   <= 1'b0;
        end else begin
            r_ped_lvl <= w_ped_lvl;
            ped_req   <= w_ped_set | (ped_req & ~ped_ack);
        end
    end

    // Step-enable divider: tick follows the terminal count by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
            tick   <= 1'b0;
        end else if (w_tick_clear) begin
            r_tcnt <= '0;
            tick   <= 1'b0;
        end else if (r_tcnt == C_TCNT_LAST) begin
            r_tcnt <= '0;
            tick   <= 1'b1;
        end else begin
            r_tcnt <= r_tcnt + C_TCNT_ONE;
            tick   <= 1'b0;
        end
    end

endmodule
`default_nettype wire
